// File: rtl/shift_unit_arbiter_pkg.sv
// Shared constants for the shift unit arbiter: Sel codes, FSM encoding, default width.
package shift_unit_arbiter_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [2:0] SEL_SHR3 = 3'b000;
  localparam logic [2:0] SEL_SHL2 = 3'b001;
  localparam logic [2:0] SEL_ROR1 = 3'b010;
  localparam logic [2:0] SEL_HOLD = 3'b011;
  localparam logic [2:0] SEL_CLR  = 3'b100;
  localparam logic [2:0] SEL_INV  = 3'b101;
  localparam logic [2:0] SEL_PASS = 3'b110;
  localparam logic [2:0] SEL_ROT2 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EXEC = 2'b10,
    ST_CAPT = 2'b11
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// Requester and shift-unit signal bundle; slave side is the arbiter.
interface shift_unit_arbiter_if
  import shift_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [2:0]       op0;
  logic [WIDTH-1:0] data1;
  logic [2:0]       op1;
  logic [1:0]       ack;
  logic [1:0]       done;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic [WIDTH-1:0] sr_in;
  logic [2:0]       sr_sel;
  logic             sr_load;
  logic [WIDTH-1:0] sr_result;

  modport master (
    output req, data0, op0, data1, op1, sr_result,
    input  ack, done, rdata, busy, sr_in, sr_sel, sr_load
  );

  modport slave (
    input  req, data0, op0, data1, op1, sr_result,
    output ack, done, rdata, busy, sr_in, sr_sel, sr_load
  );
endinterface

// File: rtl/shift_unit_arbiter_rr.sv
// Two-way round-robin grant; a tie goes to the requester not granted last time.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_o,
  output logic       valid_o
);
  logic last_q, last_d;

  // Grant decode and pointer update on an accepted grant.
  always_comb begin
    valid_o = |req_i;
    gnt_o   = 1'b0;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_q;
      default: gnt_o = 1'b0;
    endcase
    last_d = (take_i && valid_o) ? gnt_o : last_q;
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/shift_unit_arbiter.sv
// Arbitrates two requesters onto one shift unit: load, execute, capture, return.
//   state | meaning
//   IDLE  | waiting; grant decided here, rdata captured when a capture is pending
//   LOAD  | ack visible; schedules sr_load with latched operand
//   EXEC  | schedules sr_sel = latched op
//   CAPT  | schedules Sel back to idle and the result capture
// Unit-facing outputs are registered, so the unit sees each phase one cycle after the state.
module shift_unit_arbiter
  import shift_unit_arbiter_pkg::*;
#(
  parameter int         WIDTH    = WIDTH_DEF,
  parameter logic [2:0] IDLE_SEL = SEL_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  shift_unit_arbiter_if.slave bus
);
  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] sr_in_q, sr_in_d;
  logic [2:0]       sr_sel_q, sr_sel_d;
  logic             sr_load_q, sr_load_d;
  logic             cap_q, cap_d;
  logic             arb_gnt, arb_valid, arb_take;

  assign arb_take = (state_q == ST_IDLE) && arb_valid;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (bus.req),
    .take_i  (arb_take),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    data_d    = data_q;
    op_d      = op_q;
    ack_d     = 2'b00;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    sr_in_d   = sr_in_q;
    sr_sel_d  = IDLE_SEL;
    sr_load_d = 1'b0;
    cap_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          data_d  = arb_gnt ? bus.data1 : bus.data0;
          op_d    = arb_gnt ? bus.op1 : bus.op0;
          ack_d   = onehot2(arb_gnt);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_load_d = 1'b1;
        sr_in_d   = data_q;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        sr_sel_d = op_q;
        state_d  = ST_CAPT;
      end
      ST_CAPT: begin
        cap_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // gnt_q still names the finishing requester even if a new grant lands this cycle.
    if (cap_q) begin
      rdata_d = bus.sr_result;
      done_d  = onehot2(gnt_q);
    end
  end

  // State and output registers; reset drops any in-flight op without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      data_q    <= '0;
      op_q      <= 3'b000;
      ack_q     <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      sr_in_q   <= '0;
      sr_sel_q  <= IDLE_SEL;
      sr_load_q <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      data_q    <= data_d;
      op_q      <= op_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      sr_in_q   <= sr_in_d;
      sr_sel_q  <= sr_sel_d;
      sr_load_q <= sr_load_d;
      cap_q     <= cap_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.sr_in   = sr_in_q;
  assign bus.sr_sel  = sr_sel_q;
  assign bus.sr_load = sr_load_q;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter with a behavioural 4-bit shift unit attached.
module tb_shift_unit_arbiter;
  import shift_unit_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_unit_arbiter_if #(.WIDTH(4)) bus ();

  shift_unit_arbiter #(.WIDTH(4), .IDLE_SEL(SEL_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shift unit: operand register loaded by sr_load, result registered from Sel.
  logic [3:0] u_opnd, u_res;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_opnd <= 4'b0000;
      u_res  <= 4'b0000;
    end else if (bus.sr_load) begin
      u_opnd <= bus.sr_in;
    end else begin
      case (bus.sr_sel)
        SEL_SHR3: u_res <= u_opnd >> 3;
        SEL_SHL2: u_res <= u_opnd << 2;
        SEL_ROR1: u_res <= {u_opnd[0], u_opnd[3:1]};
        SEL_HOLD: u_res <= u_res;
        SEL_CLR:  u_res <= 4'b0000;
        SEL_INV:  u_res <= ~u_opnd;
        SEL_PASS: u_res <= u_opnd;
        default:  u_res <= {u_opnd[1:0], u_opnd[3:2]};
      endcase
    end
  end
  assign bus.sr_result = u_res;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] done;
    logic [3:0] rdata;
    logic [3:0] data;
    logic [2:0] op;
    int         ack_cyc;
  } sb_t;
  sb_t sbq[$];
  sb_t popped;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: load/Sel sequencing every cycle, done/rdata against the scoreboard.
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      if (bus.sr_load) begin
        if (sbq.size() == 0) check("load_without_op", 32'(bus.sr_load), 32'd0);
        else                 check("sr_in_at_load", 32'(bus.sr_in), 32'(sbq[0].data));
      end
      if (prev_load) begin
        if (sbq.size() == 0) check("exec_without_op", 32'(prev_load), 32'd0);
        else                 check("sr_sel_exec", 32'(bus.sr_sel), 32'(sbq[0].op));
      end else begin
        check("sr_sel_idle", 32'(bus.sr_sel), 32'(SEL_HOLD));
      end
      prev_load = bus.sr_load;
      if (bus.done != 2'b00) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          popped = sbq.pop_front();
          check("done", 32'(bus.done), 32'(popped.done));
          check("rdata", 32'(bus.rdata), 32'(popped.rdata));
          check("done_latency", 32'(cyc - popped.ack_cyc), 32'd4);
        end
      end
    end
  end

  task automatic wait_ack(input logic [1:0] exp_ack, input logic [3:0] exp_data,
                          input logic [2:0] exp_op, input logic [3:0] exp_rdata,
                          output int lat);
    sb_t e;
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (bus.ack == 2'b00 && lat < 20);
    check("ack", 32'(bus.ack), 32'(exp_ack));
    if (bus.ack != 2'b00) begin
      e.done    = exp_ack;
      e.rdata   = exp_rdata;
      e.data    = exp_data;
      e.op      = exp_op;
      e.ack_cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drain(output int busy_cnt);
    int n = 0;
    busy_cnt = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      busy_cnt += int'(bus.busy);
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},     32'(bus.ack),     32'd0);
    check({tag, "_done"},    32'(bus.done),    32'd0);
    check({tag, "_rdata"},   32'(bus.rdata),   32'd0);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_sr_in"},   32'(bus.sr_in),   32'd0);
    check({tag, "_sr_load"}, 32'(bus.sr_load), 32'd0);
    check({tag, "_sr_sel"},  32'(bus.sr_sel),  32'(SEL_HOLD));
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] d0;
    logic [2:0] o0;
    logic [3:0] d1;
    logic [2:0] o1;
    logic [1:0] exp_ack;
    logic [3:0] exp_rdata;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, a0;
    vecs[0] = '{2'b01, 4'b1011, SEL_SHR3, 4'b0000, SEL_SHR3, 2'b01, 4'b0001};
    vecs[1] = '{2'b10, 4'b0000, SEL_SHR3, 4'b1011, SEL_ROR1, 2'b10, 4'b1101};
    vecs[2] = '{2'b10, 4'b0000, SEL_SHR3, 4'b1011, SEL_ROT2, 2'b10, 4'b1110};
    vecs[3] = '{2'b10, 4'b0000, SEL_SHR3, 4'b1011, SEL_SHL2, 2'b10, 4'b1100};
    vecs[4] = '{2'b01, 4'b0110, SEL_PASS, 4'b0000, SEL_SHR3, 2'b01, 4'b0110};
    vecs[5] = '{2'b01, 4'b1111, SEL_HOLD, 4'b0000, SEL_SHR3, 2'b01, 4'b0110};
    vecs[6] = '{2'b10, 4'b0000, SEL_SHR3, 4'b1111, SEL_CLR,  2'b10, 4'b0000};
    vecs[7] = '{2'b01, 4'b0101, SEL_INV,  4'b0000, SEL_SHR3, 2'b01, 4'b1010};
    vecs[8] = '{2'b11, 4'b0001, SEL_PASS, 4'b1001, SEL_ROT2, 2'b10, 4'b0110};
    vecs[9] = '{2'b11, 4'b0111, SEL_SHR3, 4'b1100, SEL_PASS, 2'b01, 4'b0000};

    bus.req = 2'b00;
    bus.data0 = 4'b0000; bus.op0 = 3'b000;
    bus.data1 = 4'b0000; bus.op1 = 3'b000;
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      bus.req = vecs[i].req;
      bus.data0 = vecs[i].d0; bus.op0 = vecs[i].o0;
      bus.data1 = vecs[i].d1; bus.op1 = vecs[i].o1;
      if (vecs[i].exp_ack == 2'b01)
        wait_ack(vecs[i].exp_ack, vecs[i].d0, vecs[i].o0, vecs[i].exp_rdata, lat);
      else
        wait_ack(vecs[i].exp_ack, vecs[i].d1, vecs[i].o1, vecs[i].exp_rdata, lat);
      check("ack_latency", 32'(lat), 32'd1);
      bus.req = 2'b00;
      bus.data0 = 4'($urandom); bus.op0 = 3'($urandom);
      bus.data1 = 4'($urandom); bus.op1 = 3'($urandom);
      a0 = int'(bus.busy);
      drain(bcnt);
      check("busy_cycles", 32'(a0 + bcnt), 32'd3);
    end

    // Fresh reset, then both requesting continuously: 0,1,0 every 4 cycles.
    rst = 1'b1;
    sbq.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    bus.req = 2'b11;
    bus.data0 = 4'b0011; bus.op0 = SEL_INV;
    bus.data1 = 4'b1000; bus.op1 = SEL_PASS;
    wait_ack(2'b01, 4'b0011, SEL_INV, 4'b1100, lat);
    a0 = cyc;
    wait_ack(2'b10, 4'b1000, SEL_PASS, 4'b1000, lat);
    check("rr_interval_1", 32'(cyc - a0), 32'd4);
    a0 = cyc;
    wait_ack(2'b01, 4'b0011, SEL_INV, 4'b1100, lat);
    check("rr_interval_2", 32'(cyc - a0), 32'd4);
    bus.req = 2'b00;
    drain(bcnt);

    // Reset while the op is in EXEC: drop it silently.
    bus.req = 2'b01;
    bus.data0 = 4'b1011; bus.op0 = SEL_PASS;
    wait_ack(2'b01, 4'b1011, SEL_PASS, 4'b1011, lat);
    bus.req = 2'b00;
    @(negedge clk);
    #1;
    check("pre_reset_load", 32'(bus.sr_load), 32'd1);
    rst = 1'b1;
    sbq.delete();
    #1 check_reset_outputs("midop");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    bus.req = 2'b11;
    bus.data0 = 4'b0101; bus.op0 = SEL_SHL2;
    bus.data1 = 4'b0110; bus.op1 = SEL_SHR3;
    wait_ack(2'b01, 4'b0101, SEL_SHL2, 4'b0100, lat);
    check("post_reset_ack_latency", 32'(lat), 32'd1);
    bus.req = 2'b00;
    drain(bcnt);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
